// File: rtl/matrix_result_drain.sv
// Result unload for the 4x4 systolic array: settle, snapshot all 16 results, stream them out.
// Optional build macro DRAIN_COLMAJOR_EN selects column-major stream order (row-major otherwise).
module matrix_result_drain #(
  parameter int W      = 8,
  parameter int SETTLE = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [16*W-1:0] res_i,
  output logic            busy,
  output logic            snap,
  output logic [W-1:0]    m_data,
  output logic [3:0]      m_idx,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_CAPT   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;
  localparam int CW = $clog2(SETTLE + 1);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [16*W-1:0] snap_buf;
  logic [3:0]      ptr;
  logic [3:0]      nxt_ptr;
  logic [3:0]      nxt_idx;
  logic            beat_ok;

  // Maps stream position to the {r,c} index of the element sent at that position.
  function automatic logic [3:0] order_idx(input logic [3:0] p);
`ifdef DRAIN_COLMAJOR_EN
    return {p[1:0], p[3:2]};
`else
    return p;
`endif
  endfunction

  // Handshake: a beat transfers on any rising edge where m_valid && m_ready; while
  // m_valid is high and m_ready low, m_data/m_idx/m_last hold their values.
  assign beat_ok   = m_valid && m_ready;
  assign nxt_ptr   = ptr + 4'd1;
  assign nxt_idx   = order_idx(nxt_ptr);
  assign busy      = (state != S_IDLE);
  assign snap      = (state == S_CAPT);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      snap_buf <= '0;
      ptr      <= 4'd0;
      m_data   <= '0;
      m_idx    <= 4'd0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          // The counter reaches SETTLE-1 as CAPT is entered, placing snap SETTLE cycles after start.
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SETTLE - 2)) state <= S_CAPT;
        end
        S_CAPT: begin
          snap_buf <= res_i;
          ptr      <= 4'd0;
          // Position 0 is element (0,0) in either order, so present it straight from res_i.
          m_data   <= res_i[W-1:0];
          m_idx    <= 4'd0;
          m_valid  <= 1'b1;
          m_last   <= 1'b0;
          state    <= S_STREAM;
        end
        S_STREAM: begin
          if (beat_ok) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= S_IDLE;
            end else begin
              ptr    <= nxt_ptr;
              m_data <= snap_buf[int'(nxt_idx)*W +: W];
              m_idx  <= nxt_idx;
              m_last <= (nxt_ptr == 4'd15);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_drain.sv
// Bench for matrix_result_drain: randomized result sets checked against an ordered expected queue.
module tb_matrix_result_drain;
  localparam int W      = 8;
  localparam int SETTLE = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            m_ready = 1'b0;
  logic [16*W-1:0] res_i = '0;
  logic            busy, snap, m_valid, m_last;
  logic [W-1:0]    m_data;
  logic [3:0]      m_idx;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W+3:0] exp_q[$];
  logic [W-1:0] vals[16];

  always #5 clk = ~clk;

  matrix_result_drain #(.W(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_i(res_i),
    .busy(busy), .snap(snap), .m_data(m_data), .m_idx(m_idx),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .dbg_state(dbg_state)
  );

  // Fill the array results and build the expected beat sequence {idx, data} in stream order.
  task automatic load_vals(input bit identity);
    for (int k = 0; k < 16; k++) begin
      vals[k] = identity ? W'(k + 1) : W'($urandom_range(0, 255));
      res_i[k*W +: W] = vals[k];
    end
    exp_q.delete();
`ifdef DRAIN_COLMAJOR_EN
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        exp_q.push_back({4'(4*r + c), vals[4*r + c]});
`else
    for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), vals[k]});
`endif
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0; 2: random ready.
  task automatic run_op(input int mode, input int extra_a, input int extra_b, input bit clobber);
    int beats, snaps, snap_t, first_v, done_t;
    logic [W-1:0] pd;
    logic [3:0] pi;
    logic pl, pstall;
    logic [W+3:0] e;
    beats = 0; snaps = 0; snap_t = -1; first_v = -1; done_t = -1;
    pstall = 1'b0; pd = '0; pi = '0; pl = 1'b0;
    for (int t = 0; t < 400 && done_t < 0; t++) begin
      @(negedge clk);
      start = (t == 0) || (t == extra_a) || (t == extra_b);
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (t % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (clobber && snap_t >= 0 && t == snap_t + 1) res_i = {16*W{1'b1}};
      checks++;
      if (busy !== (t != 0)) begin
        errors++; $display("FAIL busy t=%0d got %b want %b", t, busy, (t != 0));
      end
      if (snap === 1'b1) begin
        snaps++;
        if (snap_t < 0) snap_t = t;
      end
      if (pstall) begin
        checks++;
        if ({m_data, m_idx, m_last} !== {pd, pi, pl}) begin
          errors++;
          $display("FAIL stall_hold t=%0d got %h/%0d/%b want %h/%0d/%b", t, m_data, m_idx, m_last, pd, pi, pl);
        end
      end
      if (m_valid === 1'b1 && first_v < 0) first_v = t;
      if (m_valid === 1'b1 && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_beat t=%0d idx %0d data %h", t, m_idx, m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_idx, m_data} !== e || m_last !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL beat t=%0d got idx %0d data %h last %b want idx %0d data %h last %b",
                     t, m_idx, m_data, m_last, e[W+3:W], e[W-1:0], (exp_q.size() == 0));
          end
        end
        beats++;
        if (mode == 0) begin
          checks++;
          if (t != SETTLE + beats) begin
            errors++; $display("FAIL beat_time got %0d want %0d", t, SETTLE + beats);
          end
        end
        if (m_last === 1'b1) done_t = t;
      end
      pstall = (m_valid === 1'b1) && !m_ready;
      pd = m_data; pi = m_idx; pl = m_last;
    end
    checks++;
    if (done_t < 0) begin errors++; $display("FAIL timeout got no last beat want one"); end
    checks++;
    if (beats != 16) begin errors++; $display("FAIL beat_count got %0d want 16", beats); end
    checks++;
    if (snaps != 1 || snap_t != SETTLE) begin
      errors++; $display("FAIL snap got count %0d at %0d want 1 at %0d", snaps, snap_t, SETTLE);
    end
    checks++;
    if (first_v != SETTLE + 1) begin
      errors++; $display("FAIL first_valid got %0d want %0d", first_v, SETTLE + 1);
    end
    @(negedge clk);
    start = 1'b0;
    m_ready = 1'($urandom_range(0, 1));
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== pd || m_idx !== pi) begin
      errors++;
      $display("FAIL idle_after got busy %b valid %b last %b data %h idx %0d want 0 0 0 %h %0d",
               busy, m_valid, m_last, m_data, m_idx, pd, pi);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 0 || snap !== 0 || m_valid !== 0 || m_last !== 0 || m_data !== 0 || m_idx !== 0) begin
      errors++;
      $display("FAIL reset_state got busy %b snap %b valid %b last %b data %h idx %0d want all 0",
               busy, snap, m_valid, m_last, m_data, m_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    load_vals(1'b1);
    run_op(0, -1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    load_vals(1'b1);
    run_op(1, -1, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      load_vals(1'b0);
      run_op(2, -1, -1, 1'b0);
    end
  endtask

  task automatic test_snapshot_isolation();
    load_vals(1'b1);
    run_op(0, -1, -1, 1'b1);
  endtask

  task automatic test_start_while_busy();
    load_vals(1'b0);
    run_op(0, 5, 20, 1'b0);
  endtask

  task automatic test_start_on_last();
    load_vals(1'b0);
    run_op(0, SETTLE + 16, -1, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || snap !== 1'b0) begin
      errors++; $display("FAIL start_on_last got busy %b snap %b want 0 0", busy, snap);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    load_vals(1'b0);
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b1;
    for (int t = 0; t < 100 && n < 7; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid === 1'b1) n++;
    end
    checks++;
    if (n != 7) begin errors++; $display("FAIL reset_mid_beats got %0d want 7", n); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 0 || busy !== 0 || m_idx !== 0 || m_data !== 0 || m_last !== 0 || snap !== 0) begin
      errors++;
      $display("FAIL reset_mid got valid %b busy %b idx %0d data %h last %b want all 0",
               m_valid, busy, m_idx, m_data, m_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_vals(1'b0);
    run_op(0, -1, -1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_backpressure();
    test_snapshot_isolation();
    test_start_while_busy();
    test_start_on_last();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
